deal_sequencer: RTL

Controls the card dealer's rotating motor and card feeder. Deals a set number of cards to each of 2-4 seats in round-robin order. Drives the 2-bit motor_state code that the seven-segment display block shows, and reads the seat count from that block. Sits between the user buttons, the motor/feeder drivers and the display.

---
 rtl/dealer_pkg.sv | 21 ++
 rtl/cycle_timer.sv | 29 ++
 rtl/deal_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dealer_pkg.sv
// Shared dealer definitions: the motor_state encoding the display block also decodes,
// the legal seat range and the datapath widths.
package dealer_pkg;

  typedef enum logic [1:0] {
    RESET  = 2'b00,
    ROTATE = 2'b01,
    WAIT   = 2'b10,
    REMAIN = 2'b11
  } motor_state_t;

  localparam int MIN_SEATS = 2;
  localparam int MAX_SEATS = 4;
  localparam int CARDS_W   = 6;
  localparam int TIMER_W   = 20;

  function automatic logic seat_cnt_legal(input logic [2:0] cnt);
    return (cnt >= 3'(MIN_SEATS)) && (cnt <= 3'(MAX_SEATS));
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the ROTATE and WAIT phases.
// expired flags the last cycle of a loaded period, so a load of N gives N cycles.
module cycle_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count <= WIDTH'(1));

endmodule

// File: rtl/deal_sequencer.sv
// Card dealer sequencer: deals CARDS_PER_PLAYER cards round-robin to 2..4 seats.
// Optional macro DEAL_RETRY_EN grants one feed retry before declaring the deck empty.
module deal_sequencer
  import dealer_pkg::*;
#(
  parameter int                 CARDS_PER_PLAYER = 5,
  parameter logic [TIMER_W-1:0] ROT_CYCLES       = 20'd500000,
  parameter logic [TIMER_W-1:0] WAIT_CYCLES      = 20'd750000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         seat_cnt,
  input  logic               card_seen,
  output logic [1:0]         motor_state,
  output logic               rotate_en,
  output logic               feed_en,
  output logic [1:0]         seat_idx,
  output logic [CARDS_W-1:0] cards_dealt,
  output logic               deck_empty,
  output logic               done
);

  motor_state_t       state, next_state;
  logic [2:0]         n_seats;
  logic [3:0]         round;
  logic               timer_load, timer_expired;
  logic [TIMER_W-1:0] timer_value;
  logic               start_ok, last_seat, last_card, retry_now;

  assign start_ok  = start && seat_cnt_legal(seat_cnt);
  assign last_seat = ({1'b0, seat_idx} == (n_seats - 3'd1));
  assign last_card = last_seat && (round == 4'(CARDS_PER_PLAYER - 1));

`ifdef DEAL_RETRY_EN
  logic retried;

  // One retry per card; any card arrival rearms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retried <= 1'b0;
    else if (abort || (state == RESET))
      retried <= 1'b0;
    else if ((state == WAIT) && card_seen)
      retried <= 1'b0;
    else if ((state == WAIT) && timer_expired)
      retried <= 1'b1;
  end

  assign retry_now = !retried;
`else
  assign retry_now = 1'b0;
`endif

  cycle_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (abort),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RESET;
    else
      state <= next_state;
  end

  // The timer is loaded on the same edge that enters a timed phase.
  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = WAIT_CYCLES;
    if (abort) begin
      next_state = RESET;
    end else begin
      case (state)
        RESET: begin
          if (start_ok) begin
            next_state = WAIT;
            timer_load = 1'b1;
          end
        end
        WAIT: begin
          if (card_seen) begin
            if (last_card) begin
              next_state = REMAIN;
            end else begin
              next_state  = ROTATE;
              timer_load  = 1'b1;
              timer_value = ROT_CYCLES;
            end
          end else if (timer_expired) begin
            if (retry_now)
              timer_load = 1'b1;
            else
              next_state = REMAIN;
          end
        end
        ROTATE: begin
          if (timer_expired) begin
            next_state = WAIT;
            timer_load = 1'b1;
          end
        end
        REMAIN: begin
          if (start)
            next_state = RESET;
        end
        default: next_state = RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_seats     <= '0;
      seat_idx    <= '0;
      round       <= '0;
      cards_dealt <= '0;
      deck_empty  <= 1'b0;
    end else if (abort) begin
      n_seats     <= '0;
      seat_idx    <= '0;
      round       <= '0;
      cards_dealt <= '0;
      deck_empty  <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          if (start_ok) begin
            n_seats     <= seat_cnt;
            seat_idx    <= '0;
            round       <= '0;
            cards_dealt <= '0;
            deck_empty  <= 1'b0;
          end
        end
        WAIT: begin
          if (card_seen)
            cards_dealt <= (cards_dealt == '1) ? cards_dealt : cards_dealt + 6'd1;
          else if (timer_expired && !retry_now)
            deck_empty <= 1'b1;
        end
        ROTATE: begin
          if (timer_expired) begin
            if (last_seat) begin
              seat_idx <= '0;
              round    <= round + 4'd1;
            end else begin
              seat_idx <= seat_idx + 2'd1;
            end
          end
        end
        REMAIN: begin
          if (start) begin
            seat_idx    <= '0;
            round       <= '0;
            cards_dealt <= '0;
            deck_empty  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    motor_state = state;
    rotate_en   = (state == ROTATE);
    feed_en     = (state == WAIT);
    done        = (state == REMAIN);
  end

endmodule
